// File: rtl/instr_encoder_if.sv
// Request/response bundle between the test harness and instr_encoder.
// Latency: none, wires only.
// Backpressure: in_valid_i/in_ready_o on the request side, out_valid_o/out_ready_i on the output side.
// Ports: request fields (fmt_i, opcode_i, rd_i, funct3_i, rs1_i, rs2_i, funct7_i, imm_i),
//        encoded output (out_instr_o, out_addr_o, out_err_o) and both handshakes.
// master = harness side, slave = encoder side.
interface instr_encoder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  modport master (
    output in_valid_i, fmt_i, opcode_i, rd_i, funct3_i, rs1_i, rs2_i, funct7_i, imm_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
  );

  modport slave (
    input  in_valid_i, fmt_i, opcode_i, rd_i, funct3_i, rs1_i, rs2_i, funct7_i, imm_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields plus a signed immediate into instruction words, each tagged with a byte address.
// Latency: request accepted at edge k is at the output after edge k+1 (empty FIFO); 1+OUT_DEPTH words in flight.
// Backpressure: in_ready_o = !s1_vld || fifo space; combinational from out_ready_i.
// Ports: clk_i, rst_i (async, active low), clr_i (sync clear), bus (instr_encoder_if.slave).
// Optional: define INSTR_ENC_RANGE_CHECK_EN to flag out-of-range / misaligned immediates.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  instr_encoder_if.slave bus
);

  localparam int unsigned PW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  // ---------------- range check ----------------
  logic range_bad;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(bus.imm_i);

  always_comb begin
    range_bad = 1'b0;
    case (bus.fmt_i)
      FMT_I, FMT_S: range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_B:        range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.imm_i[0];
      FMT_J:        range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.imm_i[0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  // Without the check the upper immediate bits are simply truncated.
  logic unused_imm_hi;
  assign unused_imm_hi = ^bus.imm_i[31:21];
  assign range_bad     = 1'b0;
`endif

  // ---------------- packing ----------------
  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (bus.fmt_i)
      FMT_R: enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
      FMT_I: enc_word = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
      FMT_S: enc_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                         bus.imm_i[4:0], bus.opcode_i};
      FMT_B: enc_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                         bus.imm_i[4:1], bus.imm_i[11], bus.opcode_i};
      FMT_J: enc_word = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11], bus.imm_i[19:12],
                         bus.rd_i, bus.opcode_i};
      default: enc_err = 1'b1;  // illegal format: all-zero word
    endcase
    // A failed range check still emits an entry, but as a zero word with the error bit.
    if (range_bad) begin
      enc_word = '0;
      enc_err  = 1'b1;
    end
  end

  // ---------------- handshakes ----------------
  logic          s1_vld, s1_err;
  logic [31:0]   s1_instr, s1_addr, addr_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          fifo_full, head_vld, space, push, pop, accept;

  assign fifo_full = (cnt == CW'(OUT_DEPTH));
  assign head_vld  = (cnt != '0);
  // space ignores clr_i so in_ready_o stays a plain function of occupancy and out_ready_i.
  assign space     = !fifo_full || (head_vld && bus.out_ready_i);
  assign push      = s1_vld && space && !clr_i;
  assign pop       = head_vld && bus.out_ready_i && !clr_i;
  assign accept    = bus.in_valid_i && bus.in_ready_o && !clr_i;

  assign bus.in_ready_o = !s1_vld || space;

  // Stage 1: encode register plus address counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_vld   <= 1'b0;
      s1_err   <= 1'b0;
      s1_instr <= '0;
      s1_addr  <= '0;
      addr_cnt <= BASE_ADDR;
    end else if (clr_i) begin
      s1_vld   <= 1'b0;
      addr_cnt <= BASE_ADDR;
    end else if (accept) begin
      s1_vld   <= 1'b1;
      s1_err   <= enc_err;
      s1_instr <= enc_word;
      s1_addr  <= addr_cnt;
      addr_cnt <= addr_cnt + 32'd4;
    end else if (push) begin
      s1_vld <= 1'b0;
    end
  end

  // Output FIFO. When full, a same-edge pop frees the slot being written (wr_ptr == rd_ptr).
  logic [31:0] mem_instr [OUT_DEPTH];
  logic [31:0] mem_addr  [OUT_DEPTH];
  logic        mem_err   [OUT_DEPTH];
  logic [31:0] last_instr, last_addr;
  logic        last_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_instr <= '0;
      last_addr  <= '0;
      last_err   <= 1'b0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_instr[i] <= '0;
        mem_addr[i]  <= '0;
        mem_err[i]   <= 1'b0;
      end
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= s1_instr;
        mem_addr[wr_ptr]  <= s1_addr;
        mem_err[wr_ptr]   <= s1_err;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        // Keep the popped entry so the outputs hold it once the FIFO runs empty.
        last_instr <= mem_instr[rd_ptr];
        last_addr  <= mem_addr[rd_ptr];
        last_err   <= mem_err[rd_ptr];
        rd_ptr     <= rd_ptr + PW'(1);
      end
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  assign bus.out_valid_o = head_vld;
  assign bus.out_instr_o = head_vld ? mem_instr[rd_ptr] : last_instr;
  assign bus.out_addr_o  = head_vld ? mem_addr[rd_ptr]  : last_addr;
  assign bus.out_err_o   = head_vld ? mem_err[rd_ptr]   : last_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder with a queue-based reference model.
// Latency: n/a.
// Backpressure: bench drives out_ready_i both held-low and randomly toggled.
module tb_instr_encoder;
  logic clk_i = 1'b0;
  logic rst_i;
  logic clr_i;

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .OUT_DEPTH(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  int          ncmp = 0;
  int          nfail = 0;
  ent_t        sb[$];
  logic [31:0] exp_addr;
  logic [31:0] last_pop_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: places each immediate bit by shift-and-mask arithmetic.
  function automatic ent_t ref_enc(input int fmt, input int op, input int rd, input int f3,
                                   input int rs1, input int rs2, input int f7, input int imm,
                                   input logic [31:0] addr);
    ent_t e;
    logic [31:0] u;
    logic [31:0] base;
    logic bad;
    u    = imm;
    base = op + (f3 << 12) + (rs1 << 15);
    bad  = 1'b0;
    e.addr = addr;
    e.err  = 1'b0;
    case (fmt)
      0: e.instr = base + (rd << 7) + (rs2 << 20) + (f7 << 25);
      1: e.instr = base + (rd << 7) + ((u & 32'hFFF) << 20);
      2: e.instr = base + (rs2 << 20) + ((u & 32'h1F) << 7) + (((u >> 5) & 32'h7F) << 25);
      3: e.instr = base + (rs2 << 20) + (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3F) << 25)
                   + (((u >> 1) & 32'hF) << 8) + (((u >> 11) & 1) << 7);
      4: e.instr = op + (rd << 7) + (((u >> 20) & 1) << 31) + (((u >> 1) & 32'h3FF) << 21)
                   + (((u >> 11) & 1) << 20) + (((u >> 12) & 32'hFF) << 12);
      default: begin e.instr = 32'h0; e.err = 1'b1; end
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    case (fmt)
      1, 2: bad = (imm < -2048) || (imm > 2047);
      3:    bad = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
      4:    bad = (imm < -(1 << 20)) || (imm > (1 << 20) - 2) || ((imm & 1) != 0);
      default: bad = 1'b0;
    endcase
`endif
    if (bad) begin
      e.instr = 32'h0;
      e.err   = 1'b1;
    end
    return e;
  endfunction

  task automatic set_req(input int fmt, input int op, input int rd, input int f3,
                         input int rs1, input int rs2, input int f7, input int imm);
    bus.fmt_i    = 3'(fmt);
    bus.opcode_i = 7'(op);
    bus.rd_i     = 5'(rd);
    bus.funct3_i = 3'(f3);
    bus.rs1_i    = 5'(rs1);
    bus.rs2_i    = 5'(rs2);
    bus.funct7_i = 7'(f7);
    bus.imm_i    = imm;
  endtask

  // Present one request and hold it until it is accepted (bounded).
  task automatic do_req(input int fmt, input int op, input int rd, input int f3,
                        input int rs1, input int rs2, input int f7, input int imm);
    logic acc;
    acc = 1'b0;
    set_req(fmt, op, rd, f3, rs1, rs2, f7, imm);
    bus.in_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      acc = bus.in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) break;
    end
    bus.in_valid_i = 1'b0;
    if (!acc) chk("req_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  // Wait (bounded) for a head entry, compare it, then pop it.
  task automatic expect_head(input string tag, input logic [31:0] instr,
                             input logic [31:0] addr, input logic err);
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid_o) break;
      @(posedge clk_i);
      #1;
    end
    chk({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd1);
    chk({tag, "_instr"}, bus.out_instr_o, instr);
    chk({tag, "_addr"},  bus.out_addr_o, addr);
    chk({tag, "_err"},   {31'd0, bus.out_err_o}, {31'd0, err});
    last_pop_instr  = bus.out_instr_o;
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
  endtask

  initial begin
    int   acc_n;
    int   bnd[12];
    int   imm;
    logic pop;
    ent_t e;
    bnd = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 3, 1048574, 1048576, -1048576, -1048578};

    rst_i = 1'b0;
    clr_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    last_pop_instr = 32'h0;

    // ---- reset state ----
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst_out_instr", bus.out_instr_o, 32'h0);
    chk("rst_out_addr",  bus.out_addr_o, 32'h0);
    chk("rst_out_err",   {31'd0, bus.out_err_o}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // ---- addi x1,x0,5 with latency check ----
    do_req(1, 7'b0010011, 1, 0, 0, 0, 0, 5);
    chk("lat_edge_k", {31'd0, bus.out_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("lat_edge_k1", {31'd0, bus.out_valid_o}, 32'd1);
    expect_head("addi", 32'h0050_0093, 32'h0, 1'b0);
    chk("hold_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("hold_instr", bus.out_instr_o, 32'h0050_0093);
    chk("hold_addr",  bus.out_addr_o, 32'h0);

    // ---- other formats ----
    do_req(2, 7'b0100011, 0, 3'b010, 1, 2, 0, 8);
    expect_head("sw", 32'h0020_A423, 32'h4, 1'b0);
    do_req(3, 7'b1100011, 0, 0, 0, 0, 0, -4);
    expect_head("beq", 32'hFE00_0EE3, 32'h8, 1'b0);
    do_req(4, 7'b1101111, 1, 0, 0, 0, 0, 8);
    expect_head("jal", 32'h0080_00EF, 32'hC, 1'b0);
    do_req(6, 7'b0010011, 1, 0, 0, 0, 0, 5);
    expect_head("illegal_fmt", 32'h0, 32'h10, 1'b1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    do_req(1, 7'b0010011, 1, 0, 0, 0, 0, 2048);
    expect_head("imm_2048", 32'h0, 32'h14, 1'b1);
    do_req(3, 7'b1100011, 0, 0, 0, 0, 0, 3);
    expect_head("b_odd", 32'h0, 32'h18, 1'b1);
`else
    do_req(1, 7'b0010011, 1, 0, 0, 0, 0, 2048);
    expect_head("imm_2048", 32'h8000_0093, 32'h14, 1'b0);
    do_req(3, 7'b1100011, 0, 0, 0, 0, 0, 3);
    expect_head("b_odd", 32'h0000_0163, 32'h18, 1'b0);
`endif

    // ---- backpressure: capacity is S1 + 2 FIFO entries ----
    pulse_clr();
    chk("clr_empty", {31'd0, bus.out_valid_o}, 32'd0);
    exp_addr = 32'h0;
    acc_n = 0;
    bus.in_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (acc_n == 3) break;
      set_req(1, 7'h13, acc_n + 1, 0, 0, 0, 0, acc_n * 3);
      #1;
      if (bus.in_ready_o) begin
        sb.push_back(ref_enc(1, 7'h13, acc_n + 1, 0, 0, 0, 0, acc_n * 3, exp_addr));
        exp_addr += 32'd4;
        acc_n++;
      end
      @(posedge clk_i);
      #1;
    end
    chk("bp_accepted", acc_n, 32'd3);
    set_req(1, 7'h13, 4, 0, 0, 0, 0, 9);
    #1;
    chk("bp_ready_low", {31'd0, bus.in_ready_o}, 32'd0);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_ready_rise", {31'd0, bus.in_ready_o}, 32'd1);
    chk("bp_head_addr", bus.out_addr_o, sb[0].addr);
    chk("bp_head_instr", bus.out_instr_o, sb[0].instr);
    void'(sb.pop_front());
    sb.push_back(ref_enc(1, 7'h13, 4, 0, 0, 0, 0, 9, exp_addr));
    exp_addr += 32'd4;
    @(posedge clk_i);
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      expect_head("bp_drain", e.instr, e.addr, e.err);
    end

    // ---- clr mid-stream drops everything and reloads the address ----
    do_req(0, 7'h33, 3, 1, 4, 5, 6, 0);
    do_req(0, 7'h33, 7, 2, 8, 9, 10, 0);
    set_req(1, 7'h13, 2, 0, 0, 0, 0, 1);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("clr_mid_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("clr_no_pop", bus.out_instr_o, last_pop_instr);
    @(posedge clk_i);
    #1;
    chk("clr_s1_dropped", {31'd0, bus.out_valid_o}, 32'd0);
    do_req(1, 7'b0010011, 1, 0, 0, 0, 0, 5);
    expect_head("post_clr", 32'h0050_0093, 32'h0, 1'b0);

    // ---- randomized stream against the queue model ----
    pulse_clr();
    exp_addr = 32'h0;
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom_range(0, 32) - 16;
        1: imm = $urandom_range(0, 8191) - 4096;
        2: imm = bnd[$urandom_range(0, 11)];
        default: imm = $urandom;
      endcase
      set_req($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
              $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 127), imm);
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      #2;
      pop = bus.out_valid_o && bus.out_ready_i;
      if (sb.size() == 0) chk("rnd_empty_valid", {31'd0, bus.out_valid_o}, 32'd0);
      chk("rnd_in_ready", {31'd0, bus.in_ready_o}, {31'd0, (sb.size() < 3) || pop});
      if (pop && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rnd_instr", bus.out_instr_o, e.instr);
        chk("rnd_addr",  bus.out_addr_o, e.addr);
        chk("rnd_err",   {31'd0, bus.out_err_o}, {31'd0, e.err});
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        sb.push_back(ref_enc(bus.fmt_i, bus.opcode_i, bus.rd_i, bus.funct3_i, bus.rs1_i,
                             bus.rs2_i, bus.funct7_i, imm, exp_addr));
        exp_addr += 32'd4;
      end
      @(posedge clk_i);
      #1;
    end

    // ---- drain ----
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (sb.size() == 0) break;
      #2;
      if (bus.out_valid_o) begin
        e = sb.pop_front();
        chk("drain_instr", bus.out_instr_o, e.instr);
        chk("drain_addr",  bus.out_addr_o, e.addr);
        chk("drain_err",   {31'd0, bus.out_err_o}, {31'd0, e.err});
      end
      @(posedge clk_i);
      #1;
    end
    chk("drain_left", sb.size(), 32'd0);
    #2;
    chk("drain_valid", {31'd0, bus.out_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
